lab2_sub2_scheduler: RTL and testbench
======================================

# lab2_sub2_scheduler

Sequential controller that shares one combinational subtract-by-constant unit between two requesters. It performs round-robin arbitration, accepts one operand per transaction, and applies the unit iteratively (1–4 passes, modulo 2^DATA_W). It returns the result with the requester ID over a valid/ready port. It sits between the lab2 stimulus sources and the result display/checker logic.

## Interface
- DATA_W, 3, operand/result width
- SUB_K, 2, constant subtracted per pass
- ITER_W, 2, width of per-request pass count
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- req0_valid / req1_valid  input  1  requester has an operand
- req0_data / req1_data  input  DATA_W  operand
- req0_iter / req1_iter  input  ITER_W  pass count minus one
- req0_ready / req1_ready  output  1  operand accepted this cycle when high with valid
- res_valid  output  1  result available
- res_data  output  DATA_W  result
- res_id  output  1  requester that owns the result
- res_ready  input  1  consumer takes the result
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: the arbiter picks one requester.
  - If only one valid is high, that requester wins.
  - If both are high, `prio` selects the winner (0 → req0, 1 → req1).
  - The winner's ready is driven high combinationally; the loser's ready is low.
- Acceptance (valid & ready in IDLE):
  - acc ← data, cnt ← iter, id ← winner.
  - prio ← ~winner.
  - Next state is RUN.
- RUN: every cycle, acc ← (acc − SUB_K) mod 2^DATA_W.
  - If cnt ≠ 0: cnt ← cnt − 1 and stay in RUN.
  - If cnt == 0: perform the final pass and go to DONE.
- DONE: res_valid = 1, res_data = acc, res_id = id.
  - Outputs are held stable until res_ready = 1.
  - On res_valid & res_ready, go to IDLE.
- Both ready outputs are low in RUN and DONE. No request is accepted while a transaction is in flight.
- Arithmetic: DATA_W-bit two's-complement wrap; there is no borrow or overflow output. Example: 3'b001 − 2 = 3'b111.
- A requester deasserting valid before acceptance is legal; nothing is latched.

## Timing
- Reset (rst_n low at a clock edge):
  - state = IDLE, prio = 0, acc = 0, cnt = 0, id = 0.
  - Outputs: res_valid = 0, res_data = 0, res_id = 0, busy = 0.
  - req0_ready and req1_ready are forced low while rst_n is low.
- Latency: with acceptance at edge k, res_valid rises after edge k + iter + 1.
  - iter = 0 → 1 cycle.
  - iter = 3 → 4 cycles.
- Throughput: one bubble cycle. The DONE→IDLE handshake edge is followed by an IDLE cycle in which the next acceptance can occur.
  - Minimum transaction spacing is iter + 3 cycles when res_ready is held high.
- Simultaneous valids at the first IDLE cycle after reset: req0 wins.
- Continuous dual contention: grants alternate 0, 1, 0, 1, ….
- Backpressure: res_ready low for N cycles extends DONE by N cycles. res_data and res_id must not change during that time.
- Reset mid-RUN or mid-DONE: the transaction is abandoned and no result is emitted. The next cycle is IDLE with prio = 0.
- No combinational path from res_ready to req*_ready.

## Structure
- Shared package/header holds:
  - State encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Defaults for DATA_W, SUB_K, ITER_W.
- Sub-module `sub_const_unit`: purely combinational, out = in − SUB_K on DATA_W bits, parameterised by DATA_W and SUB_K.
  - Instantiated once, fed from acc.
- The arbiter stays inline; it is a few lines around prio.

## Test plan
- Single pass: req0 data 3'b101, iter 0, res_ready high.
  - Expected: res_valid 1 cycle after accept, res_data 3'b011, res_id 0.
- Wrap: req1 data 3'b001, iter 0.
  - Expected: res_data 3'b111, res_id 1.
- Multi-pass: req0 data 3'b110, iter 3.
  - Expected: res_valid exactly 4 cycles after accept, res_data 3'b110 (6 − 8 mod 8).
  - busy is high for 5 cycles.
- Contention: both valid continuously from reset release, data0 3'b100, data1 3'b111, iter 0.
  - Expected: results in order id 0 (3'b010), id 1 (3'b101), id 0, id 1.
- Backpressure: res_ready low for 3 cycles in DONE.
  - Expected: res_valid, res_data and res_id stable; both readies low; result taken on the cycle res_ready rises, then IDLE.
- Reset mid-RUN: req0 iter 3, rst_n low at the 2nd RUN cycle.
  - Expected: no res_valid, all outputs 0, next contended grant goes to req0.

Source files
------------

// File: rtl/lab2_sub2_scheduler_pkg.sv
// lab2_sub2_scheduler_pkg: shared constants for the lab2 subtract scheduler.
// Holds FSM state encodings and default widths/constants; no ports.
package lab2_sub2_scheduler_pkg;

    localparam int DATA_W_DEF = 3;
    localparam int SUB_K_DEF  = 2;
    localparam int ITER_W_DEF = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/lab2_sub2_scheduler_sub_const_unit.sv
// sub_const_unit: combinational out = in - SUB_K, wrapping on DATA_W bits.
// Ports: in_i [DATA_W] operand, out_o [DATA_W] difference.
module sub_const_unit #(
    parameter int DATA_W = 3,
    parameter int SUB_K  = 2
) (
    input  logic [DATA_W-1:0] in_i,
    output logic [DATA_W-1:0] out_o
);

    assign out_o = in_i - DATA_W'(SUB_K);

endmodule

// File: rtl/lab2_sub2_scheduler.sv
// lab2_sub2_scheduler: round-robin shares one subtract unit between two
// requesters; each operand gets iter+1 passes, result returned with its id.
// Ports: clk, rst_n (sync, active low); req0/req1 valid/data/iter in,
// req0/req1 ready out; res_valid/res_data/res_id out, res_ready in; busy out.
module lab2_sub2_scheduler
    import lab2_sub2_scheduler_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUB_K  = SUB_K_DEF,
    parameter int ITER_W = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [ITER_W-1:0] req0_iter,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [ITER_W-1:0] req1_iter,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id,
    input  logic              res_ready,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              id_q, id_d;

    logic              in_idle;
    logic              win;
    logic              grant;
    logic [DATA_W-1:0] sub_out;

    sub_const_unit #(
        .DATA_W (DATA_W),
        .SUB_K  (SUB_K)
    ) u_sub (
        .in_i  (acc_q),
        .out_o (sub_out)
    );

    assign in_idle = (state_q == ST_IDLE);

    // Lone requester wins outright; prio only breaks ties.
    assign win   = (req0_valid & req1_valid) ? prio_q : req1_valid;
    // Readies depend only on state and valids, never on res_ready.
    assign grant = rst_n & in_idle & (req0_valid | req1_valid);

    assign req0_ready = grant & ~win;
    assign req1_ready = grant & win;

    assign busy      = ~in_idle;
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = res_valid ? acc_q : '0;
    assign res_id    = res_valid & id_q;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    acc_d   = win ? req1_data : req0_data;
                    cnt_d   = win ? req1_iter : req0_iter;
                    id_d    = win;
                    prio_d  = ~win;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = sub_out;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ITER_W'(1);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_lab2_sub2_scheduler.sv
// tb_lab2_sub2_scheduler: directed plus random stimulus against a
// cycle-count reference model; results checked by a scoreboard monitor.
module tb_lab2_sub2_scheduler;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_data, req1_data;
    logic [1:0] req0_iter, req1_iter;
    logic       req0_ready, req1_ready;
    logic       res_valid;
    logic [2:0] res_data;
    logic       res_id;
    logic       res_ready;
    logic       busy;

    int total = 0;
    int bad   = 0;

    lab2_sub2_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_iter  (req0_iter),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_iter  (req1_iter),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected results as {id, data}, pushed at acceptance.
    logic [3:0] exp_q[$];

    // Reference model: free/busy, cycles until the result shows, tie priority.
    bit m_free = 1'b1;
    bit m_prio = 1'b0;
    int m_wait = 0;
    bit rst_prev_low = 1'b0;

    always @(negedge clk) begin
        bit e_valid, w, acc;
        int it, d, r;
        e_valid = !m_free && (m_wait == 0);
        w   = (req0_valid && req1_valid) ? m_prio : req1_valid;
        acc = rst_n && m_free && (req0_valid || req1_valid);
        chk("res_valid", res_valid, e_valid);
        chk("req0_ready", req0_ready, acc && !w);
        chk("req1_ready", req1_ready, acc && w);
        chk("busy", busy, !m_free);
        if (rst_prev_low) begin
            chk("rst_res_data", res_data, 0);
            chk("rst_res_id", res_id, 0);
        end
        rst_prev_low = !rst_n;
        if (!rst_n) begin
            m_free = 1'b1;
            m_prio = 1'b0;
            m_wait = 0;
            exp_q.delete();
        end else if (acc) begin
            it = w ? int'(req1_iter) : int'(req0_iter);
            d  = w ? int'(req1_data) : int'(req0_data);
            r  = (d - (it + 1) * 2) & 7;
            exp_q.push_back({w, 3'(r)});
            m_free = 1'b0;
            m_wait = it + 1;
            m_prio = !w;
        end else if (!m_free) begin
            if (m_wait > 0) m_wait--;
            else if (res_ready) m_free = 1'b1;
        end
    end

    // Monitor: pops on every result handshake, checks hold under backpressure.
    bit         hold_prev = 1'b0;
    logic [2:0] prev_data;
    logic       prev_id;

    always @(negedge clk) begin
        logic [3:0] e;
        if (rst_n && res_valid && hold_prev) begin
            chk("hold_data", res_data, prev_data);
            chk("hold_id", res_id, prev_id);
        end
        hold_prev = rst_n && res_valid && !res_ready;
        prev_data = res_data;
        prev_id   = res_id;
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("res_data", res_data, e[2:0]);
                chk("res_id", res_id, e[3]);
            end
        end
    end

    task automatic drive(input bit r, input bit v0, input int d0, input int i0,
                         input bit v1, input int d1, input int i1, input bit rr);
        @(posedge clk);
        #1;
        rst_n      = r;
        req0_valid = v0;
        req0_data  = 3'(d0);
        req0_iter  = 2'(i0);
        req1_valid = v1;
        req1_data  = 3'(d1);
        req1_iter  = 2'(i1);
        res_ready  = rr;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_iter = '0;
        req1_valid = 1'b0; req1_data = '0; req1_iter = '0;
        res_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        // contention straight out of reset
        for (int k = 0; k < 12; k++) drive(1, 1, 4, 0, 1, 7, 0, 1);
        idle(3);
        // single pass, wrap, multi-pass
        drive(1, 1, 5, 0, 0, 0, 0, 1);
        idle(3);
        drive(1, 0, 0, 0, 1, 1, 0, 1);
        idle(3);
        drive(1, 1, 6, 3, 0, 0, 0, 1);
        idle(7);
        // backpressure
        drive(1, 1, 3, 1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // reset during the second RUN cycle, then a tie
        drive(1, 1, 2, 3, 0, 0, 0, 1);
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 1, 1, 0, 1, 6, 0, 1);
        idle(4);
        // random traffic
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 99) != 0,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 7);
        end
        idle(10);
        chk("drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
